bsg_downstream_assembler: RTL and testbench
===========================================

Name: bsg_downstream_assembler

Overview:
IO-side receive and word-assembly stage that directly feeds the downstream output stage. Accepts bytes from the off-chip link under credit flow control and buffers them in a small byte FIFO. Returns one token per byte drained, packs four bytes into two 16-bit halves (core_data0/core_data1), and presents them to the output stage with a child_valid/core_ready handshake.

Parameters:
DEPTH, 8, byte FIFO entries; power of two, at least 4.
LG_DEPTH, 3, log2(DEPTH); pointers are LG_DEPTH+1 bits wide, the MSB being the wrap bit.

Ports:
clk  in  1  single clock; all state on its rising edge
rst  in  1  reset, asynchronous, active-low
io_valid_in  in  1  byte valid from IO link
io_data_in  in  8  byte from IO link
core_ready  in  1  output stage accepts the current word
io_token_out  out  1  credit return, one pulse per byte popped
child_valid  out  1  assembled word available
core_data0  out  16  word bits [15:0]
core_data1  out  16  word bits [31:16]
wptr  out  LG_DEPTH+1  FIFO write pointer
rptr  out  LG_DEPTH+1  FIFO read pointer
full  out  1  FIFO full, combinational from the pointers
overflow_err  out  1  sticky credit-violation flag

Behaviour:
- Reset (rst=0, asynchronous): wptr=rptr=0, child_valid=0, io_token_out=0, core_data0=core_data1=0, overflow_err=0, FSM=C0. All outputs hold these values until the first edge after rst deasserts.
- full = (wptr[LG_DEPTH]!=rptr[LG_DEPTH]) && (wptr[LG_DEPTH-1:0]==rptr[LG_DEPTH-1:0]). empty = (wptr==rptr).
- Write: io_valid_in && !full -> mem[wptr low bits] <= io_data_in; wptr += 1, wrapping modulo 2*DEPTH.
- io_valid_in && full -> byte dropped, wptr unchanged, overflow_err <= 1. overflow_err clears only on reset.
- FSM states: C0, C1, C2, C3 (collecting byte k), HOLD.
- In Ck with !empty: pop one byte and advance rptr. The byte lands as follows:
  - C0 -> core_data0[7:0]
  - C1 -> core_data0[15:8]
  - C2 -> core_data1[7:0]
  - C3 -> core_data1[15:8]
  - Ck advances to Ck+1; C3 advances to HOLD and sets child_valid <= 1.
- In Ck with empty: no pop, state held.
- HOLD: no pops. child_valid=1, and core_data0/1 stay stable until the handshake.
- Handshake child_valid && core_ready -> child_valid <= 0, FSM -> C0. The next pop happens one cycle later at the earliest.
- A write into an empty FIFO is not fall-through: the byte is popped at the earliest on the edge after the write edge.
- Simultaneous write and pop in the same cycle: both happen. When full, a same-cycle pop does not enable a same-cycle write; full is judged on pre-edge pointers.
- io_token_out is registered: 1 in the cycle after each pop edge, else 0. Total tokens always equal total pops.
- Latency: bytes written on edges E0..E3 back-to-back are popped on E1..E4; child_valid=1 after E4 and io_token_out=1 after E1..E4.
- Partial-word contents of core_data0/1 during C1..C3 are don't-care to the consumer; only values while child_valid=1 are defined.
- Reset asserted mid-word discards the partial word and all FIFO contents. No token is returned for discarded bytes; the link side re-initialises its credits.

Test Plan:
- Reset, then write 0x11,0x22,0x33,0x44 on consecutive cycles with core_ready=1 -> child_valid=1 after E4 with core_data0=0x2211 and core_data1=0x4433. child_valid drops one cycle later; io_token_out pulses exactly 4 times.
- core_ready=0 while 8 bytes 0x01..0x08 arrive -> first word {0x0403,0x0201} held, wptr=8, rptr=4, no pops in HOLD. Raise core_ready -> second word {0x0807,0x0605} follows; 8 tokens total.
- With core_ready=0, write 12 bytes -> full=1 at occupancy 8, the 13th write is dropped and overflow_err=1, wptr-rptr=8 at that point.
- Stream 40 bytes 0x00..0x27 with core_ready toggling every other cycle -> pointers wrap at 16. Ten words are received in order, word n = bytes 4n..4n+3 little-endian, and no overflow occurs.
- Assert rst for 1 cycle after 2 bytes of a word -> all outputs 0 immediately and asynchronously. The next 4 bytes 0xA0..0xA3 yield core_data0=0xA1A0, core_data1=0xA3A2.
- Same-cycle write and pop at occupancy 3 -> occupancy stays 3, one token pulse, data order preserved.

Source files
------------

// File: rtl/bsg_downstream_assembler.sv
// Receive-side byte FIFO with credit return, packing four bytes into a 32-bit word
// (core_data1:core_data0) presented to the output stage under a valid/ready handshake.
module bsg_downstream_assembler #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned LG_DEPTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                io_valid_in,
    input  logic [7:0]          io_data_in,
    input  logic                core_ready,
    output logic                io_token_out,
    output logic                child_valid,
    output logic [15:0]         core_data0,
    output logic [15:0]         core_data1,
    output logic [LG_DEPTH:0]   wptr,
    output logic [LG_DEPTH:0]   rptr,
    output logic                full,
    output logic                overflow_err
);

    typedef enum logic [2:0] {StC0, StC1, StC2, StC3, StHold} state_e;

    state_e              state_q, state_d;
    logic [7:0]          mem [DEPTH];
    logic [LG_DEPTH:0]   wptr_q, rptr_q;
    logic                child_valid_q, child_valid_d;
    logic                token_q;
    logic                overflow_q;
    logic [15:0]         data0_q, data0_d;
    logic [15:0]         data1_q, data1_d;
    logic                empty;
    logic                wr_en;
    logic                pop;
    logic [7:0]          rd_byte;

    // Full/empty are judged on pre-edge pointers, so a same-cycle pop never frees a slot for
    // a same-cycle write.
    assign full    = (wptr_q[LG_DEPTH] != rptr_q[LG_DEPTH]) &&
                     (wptr_q[LG_DEPTH-1:0] == rptr_q[LG_DEPTH-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign wr_en   = io_valid_in && !full;
    assign pop     = !empty && (state_q != StHold);
    assign rd_byte = mem[rptr_q[LG_DEPTH-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q[LG_DEPTH-1:0]] <= io_data_in;
        end
    end

    always_comb begin
        state_d       = state_q;
        child_valid_d = child_valid_q;
        data0_d       = data0_q;
        data1_d       = data1_q;
        unique case (state_q)
            StC0: if (pop) begin
                data0_d[7:0] = rd_byte;
                state_d      = StC1;
            end
            StC1: if (pop) begin
                data0_d[15:8] = rd_byte;
                state_d       = StC2;
            end
            StC2: if (pop) begin
                data1_d[7:0] = rd_byte;
                state_d      = StC3;
            end
            StC3: if (pop) begin
                data1_d[15:8] = rd_byte;
                state_d       = StHold;
                child_valid_d = 1'b1;
            end
            StHold: if (child_valid_q && core_ready) begin
                child_valid_d = 1'b0;
                state_d       = StC0;
            end
            default: state_d = StC0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StC0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            child_valid_q <= 1'b0;
            token_q       <= 1'b0;
            overflow_q    <= 1'b0;
            data0_q       <= '0;
            data1_q       <= '0;
        end else begin
            state_q       <= state_d;
            child_valid_q <= child_valid_d;
            data0_q       <= data0_d;
            data1_q       <= data1_d;
            token_q       <= pop;
            if (wr_en) begin
                wptr_q <= wptr_q + {{LG_DEPTH{1'b0}}, 1'b1};
            end
            if (pop) begin
                rptr_q <= rptr_q + {{LG_DEPTH{1'b0}}, 1'b1};
            end
            if (io_valid_in && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign io_token_out = token_q;
    assign child_valid  = child_valid_q;
    assign core_data0   = data0_q;
    assign core_data1   = data1_q;
    assign wptr         = wptr_q;
    assign rptr         = rptr_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_bsg_downstream_assembler.sv
// Randomised bench for bsg_downstream_assembler against a queue-based byte/word model.
module tb_bsg_downstream_assembler;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          io_valid_in = 1'b0;
    logic [7:0]    io_data_in = '0;
    logic          core_ready = 1'b0;
    logic          io_token_out;
    logic          child_valid;
    logic [15:0]   core_data0;
    logic [15:0]   core_data1;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          full;
    logic          overflow_err;

    bsg_downstream_assembler #(.DEPTH(DEPTH), .LG_DEPTH(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .io_valid_in  (io_valid_in),
        .io_data_in   (io_data_in),
        .core_ready   (core_ready),
        .io_token_out (io_token_out),
        .child_valid  (child_valid),
        .core_data0   (core_data0),
        .core_data1   (core_data1),
        .wptr         (wptr),
        .rptr         (rptr),
        .full         (full),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents, bytes collected so far, and pointer counters.
    logic [7:0]    q[$];
    logic [7:0]    col[$];
    bit            m_hold, m_token, m_ovf;
    logic [PW-1:0] m_wptr, m_rptr;
    logic [31:0]   m_word;
    int            tok_seen;
    int            n_vec = 0;
    int            n_err = 0;

    function automatic void model_clear();
        q.delete();
        col.delete();
        m_hold   = 1'b0;
        m_token  = 1'b0;
        m_ovf    = 1'b0;
        m_wptr   = '0;
        m_rptr   = '0;
        m_word   = '0;
        tok_seen = 0;
    endfunction

    task automatic cycle(input logic v, input logic [7:0] d, input logic r);
        bit mfull, dpop;
        logic [7:0] b;
        io_valid_in = v;
        io_data_in  = d;
        core_ready  = r;
        @(posedge clk);
        mfull = (q.size() == DEPTH);
        dpop  = !m_hold && (q.size() != 0);
        if (v && mfull) m_ovf = 1'b1;
        m_token = dpop;
        if (m_hold) begin
            if (r) begin
                m_hold = 1'b0;
                col.delete();
            end
        end else if (dpop) begin
            b = q.pop_front();
            col.push_back(b);
            m_rptr = m_rptr + 1'b1;
            if (col.size() == 4) begin
                m_hold = 1'b1;
                m_word = {col[3], col[2], col[1], col[0]};
            end
        end
        if (v && !mfull) begin
            q.push_back(d);
            m_wptr = m_wptr + 1'b1;
        end
        #1;
        if (io_token_out) tok_seen++;
    endtask

    task automatic do_reset();
        io_valid_in = 1'b0;
        core_ready  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        n_vec++;
        if ({wptr, rptr, child_valid, io_token_out, core_data0, core_data1, overflow_err, full}
            !== '0) begin
            n_err++;
            $display("FAIL reset_state: got wptr=%h rptr=%h cv=%b tok=%b d0=%h d1=%h ovf=%b full=%b want all 0",
                     wptr, rptr, child_valid, io_token_out, core_data0, core_data1, overflow_err, full);
        end
        rst = 1'b1;
        do_reset();
    endtask

    task automatic test_basic();
        logic [7:0] bytes [4];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(i < 4, (i < 4) ? bytes[i] : 8'h00, 1'b1);
            n_vec++;
            if ({child_valid, io_token_out, wptr, rptr, full, overflow_err} !==
                {m_hold, m_token, m_wptr, m_rptr, (q.size() == DEPTH), m_ovf}) begin
                n_err++;
                $display("FAIL basic_ctrl[%0d]: got cv=%b tok=%b w=%h r=%h full=%b ovf=%b want %b %b %h %h %b %b",
                         i, child_valid, io_token_out, wptr, rptr, full, overflow_err,
                         m_hold, m_token, m_wptr, m_rptr, (q.size() == DEPTH), m_ovf);
            end
            if (i == 4) begin
                n_vec++;
                if ({child_valid, core_data1, core_data0} !== {1'b1, 32'h4433_2211}) begin
                    n_err++;
                    $display("FAIL basic_word: got cv=%b %h_%h want 1 4433_2211",
                             child_valid, core_data1, core_data0);
                end
            end
            if (i == 5) begin
                n_vec++;
                if (child_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_drop: got cv=%b want 0", child_valid);
                end
            end
        end
        n_vec++;
        if (tok_seen !== 4) begin
            n_err++;
            $display("FAIL basic_tokens: got %0d want 4", tok_seen);
        end
    endtask

    task automatic test_hold();
        logic [31:0] words[$];
        do_reset();
        for (int i = 0; i < 11; i++) begin
            cycle(i < 8, 8'(i + 1), 1'b0);
            n_vec++;
            if ({child_valid, io_token_out, wptr, rptr, full} !==
                {m_hold, m_token, m_wptr, m_rptr, (q.size() == DEPTH)}) begin
                n_err++;
                $display("FAIL hold_ctrl[%0d]: got cv=%b tok=%b w=%h r=%h want %b %b %h %h",
                         i, child_valid, io_token_out, wptr, rptr, m_hold, m_token, m_wptr, m_rptr);
            end
        end
        n_vec++;
        if ({wptr, rptr, child_valid, core_data1, core_data0} !==
            {4'd8, 4'd4, 1'b1, 32'h0403_0201}) begin
            n_err++;
            $display("FAIL hold_state: got w=%h r=%h cv=%b %h_%h want 8 4 1 0403_0201",
                     wptr, rptr, child_valid, core_data1, core_data0);
        end
        for (int i = 0; i < 10; i++) begin
            if (child_valid) words.push_back({core_data1, core_data0});
            cycle(1'b0, 8'h00, 1'b1);
        end
        n_vec++;
        if (words.size() != 2 || words[0] !== 32'h0403_0201 || words[1] !== 32'h0807_0605) begin
            n_err++;
            $display("FAIL hold_words: got %0d words first=%h second=%h want 2 0403_0201 0807_0605",
                     words.size(), (words.size() > 0) ? words[0] : 32'h0,
                     (words.size() > 1) ? words[1] : 32'h0);
        end
        n_vec++;
        if (tok_seen !== 8) begin
            n_err++;
            $display("FAIL hold_tokens: got %0d want 8", tok_seen);
        end
    endtask

    task automatic test_overflow();
        logic [PW-1:0] w_before;
        logic [PW-1:0] occ;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 8'($urandom), 1'b0);
            n_vec++;
            if ({io_token_out, wptr, rptr, full, overflow_err} !==
                {m_token, m_wptr, m_rptr, (q.size() == DEPTH), m_ovf}) begin
                n_err++;
                $display("FAIL ovf_ctrl[%0d]: got tok=%b w=%h r=%h full=%b ovf=%b want %b %h %h %b %b",
                         i, io_token_out, wptr, rptr, full, overflow_err,
                         m_token, m_wptr, m_rptr, (q.size() == DEPTH), m_ovf);
            end
        end
        occ = wptr - rptr;
        n_vec++;
        if ({full, occ, overflow_err} !== {1'b1, 4'd8, 1'b0}) begin
            n_err++;
            $display("FAIL ovf_full: got full=%b occ=%0d ovf=%b want 1 8 0", full, occ, overflow_err);
        end
        w_before = wptr;
        cycle(1'b1, 8'($urandom), 1'b0);
        n_vec++;
        if ({overflow_err, wptr} !== {1'b1, w_before}) begin
            n_err++;
            $display("FAIL ovf_drop: got ovf=%b w=%h want 1 %h", overflow_err, wptr, w_before);
        end
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
        n_vec++;
        if ({overflow_err, full} !== {1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL ovf_sticky: got ovf=%b full=%b want 1 0", overflow_err, full);
        end
    endtask

    task automatic test_stream();
        int nxt = 0;
        int n_words = 0;
        logic v, r;
        logic [31:0] exp;
        do_reset();
        for (int cyc = 0; cyc < 2000 && n_words < 10; cyc++) begin
            r = cyc[1];
            v = (nxt < 40) && (q.size() < DEPTH) && ($urandom_range(3) != 0);
            if (child_valid && r) begin
                exp = {8'(4*n_words+3), 8'(4*n_words+2), 8'(4*n_words+1), 8'(4*n_words)};
                n_vec++;
                if ({core_data1, core_data0} !== exp) begin
                    n_err++;
                    $display("FAIL stream_word[%0d]: got %h_%h want %h",
                             n_words, core_data1, core_data0, exp);
                end
                n_words++;
            end
            cycle(v, 8'(nxt), r);
            if (v) nxt++;
            n_vec++;
            if ({child_valid, io_token_out, wptr, rptr, full, overflow_err} !==
                {m_hold, m_token, m_wptr, m_rptr, (q.size() == DEPTH), m_ovf}) begin
                n_err++;
                $display("FAIL stream_ctrl[%0d]: got cv=%b tok=%b w=%h r=%h full=%b ovf=%b want %b %b %h %h %b %b",
                         cyc, child_valid, io_token_out, wptr, rptr, full, overflow_err,
                         m_hold, m_token, m_wptr, m_rptr, (q.size() == DEPTH), m_ovf);
            end
        end
        n_vec++;
        if (n_words != 10) begin
            n_err++;
            $display("FAIL stream_timeout: got %0d words want 10", n_words);
        end
        n_vec++;
        if ({wptr, rptr, overflow_err} !== {4'd8, 4'd8, 1'b0} || tok_seen != 40) begin
            n_err++;
            $display("FAIL stream_end: got w=%h r=%h ovf=%b tokens=%0d want 8 8 0 40",
                     wptr, rptr, overflow_err, tok_seen);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b1, 8'hC3, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({wptr, rptr, child_valid, io_token_out, core_data0, core_data1, overflow_err}
            !== '0) begin
            n_err++;
            $display("FAIL midrst_async: got w=%h r=%h cv=%b tok=%b d0=%h d1=%h ovf=%b want all 0",
                     wptr, rptr, child_valid, io_token_out, core_data0, core_data1, overflow_err);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) cycle(i < 4, 8'(8'hA0 + i), 1'b0);
        n_vec++;
        if ({child_valid, core_data1, core_data0} !== {1'b1, 32'hA3A2_A1A0}) begin
            n_err++;
            $display("FAIL midrst_word: got cv=%b %h_%h want 1 A3A2_A1A0",
                     child_valid, core_data1, core_data0);
        end
    endtask

    task automatic test_simul();
        logic [PW-1:0] occ;
        do_reset();
        for (int i = 0; i < 8; i++) cycle(i != 4, 8'($urandom), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'($urandom), 1'b0);
        occ = wptr - rptr;
        n_vec++;
        if ({occ, io_token_out} !== {4'd3, 1'b1}) begin
            n_err++;
            $display("FAIL simul_occ: got occ=%0d tok=%b want 3 1", occ, io_token_out);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            n_vec++;
            if ({child_valid, io_token_out, wptr, rptr} !== {m_hold, m_token, m_wptr, m_rptr}) begin
                n_err++;
                $display("FAIL simul_ctrl[%0d]: got cv=%b tok=%b w=%h r=%h want %b %b %h %h",
                         i, child_valid, io_token_out, wptr, rptr, m_hold, m_token, m_wptr, m_rptr);
            end
        end
        n_vec++;
        if ({child_valid, core_data1, core_data0} !== {1'b1, m_word}) begin
            n_err++;
            $display("FAIL simul_word: got cv=%b %h_%h want 1 %h",
                     child_valid, core_data1, core_data0, m_word);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_hold();
        test_overflow();
        test_stream();
        test_mid_reset();
        test_simul();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
